// File: rtl/uart_tx_sched.sv
// uart_tx_sched: shares one byte-level UART transmitter between single-character host
// commands and a periodic streaming timer. Axis samples are snapshotted at grant and
// serialised as single bytes or multi-byte frames over a start/busy handshake.
// Optional feature macro: UART_FRAME_CHECKSUM_EN (appends an 8-bit sum byte to frames).
module uart_tx_sched #(
  parameter int unsigned STREAM_DIV = 5_000_000,
  parameter logic [7:0]  HDR        = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic [12:0] x_axis,
  input  logic [12:0] y_axis,
  input  logic [12:0] z_axis,
  input  logic        tx_busy,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  output logic        frame_active,
  output logic        stream_on,
  output logic        cmd_drop
);

  localparam logic [7:0] CMD_LX = 8'h78;
  localparam logic [7:0] CMD_LY = 8'h79;
  localparam logic [7:0] CMD_LZ = 8'h7A;
  localparam logic [7:0] CMD_HX = 8'h58;
  localparam logic [7:0] CMD_HY = 8'h59;
  localparam logic [7:0] CMD_HZ = 8'h5A;
  localparam logic [7:0] CMD_A  = 8'h61;
  localparam logic [7:0] CMD_S  = 8'h73;
  localparam logic [7:0] CMD_SS = 8'h53;

`ifdef UART_FRAME_CHECKSUM_EN
  localparam logic [2:0] FRAME_LAST = 3'd7;
`else
  localparam logic [2:0] FRAME_LAST = 3'd6;
`endif

  localparam logic [31:0] DIV_LAST = 32'(STREAM_DIV - 1);

  typedef enum logic [1:0] {StIdle, StSend, StAck, StDone} state_t;

  state_t      state;
  logic        cmd_pend;
  logic [7:0]  cmd_byte;
  logic        stream_pend;
  logic [31:0] stream_cnt;
  logic [7:0]  cur_cmd;
  logic [2:0]  idx;
  logic [12:0] snap_x;
  logic [12:0] snap_y;
  logic [12:0] snap_z;

  logic       grant_cmd;
  logic       grant_stream;
  logic       tick;
  logic [7:0] grant_byte;
  logic [2:0] last_idx;
  logic [2:0] idx_next;

  function automatic logic [7:0] lo(input logic [12:0] a);
    return a[7:0];
  endfunction

  function automatic logic [7:0] hi(input logic [12:0] a);
    return {a[12], a[12], a[12], a[12:8]};
  endfunction

  // Byte to transmit for a given command and byte index; 'a' selects the frame layout.
  function automatic logic [7:0] pick(input logic [7:0] cmd, input logic [2:0] i,
                                      input logic [12:0] ax, input logic [12:0] ay,
                                      input logic [12:0] az);
    logic [7:0] b;
    b = 8'h00;
    case (cmd)
      CMD_LX: b = lo(ax);
      CMD_LY: b = lo(ay);
      CMD_LZ: b = lo(az);
      CMD_HX: b = hi(ax);
      CMD_HY: b = hi(ay);
      CMD_HZ: b = hi(az);
      CMD_A: begin
        case (i)
          3'd0:    b = HDR;
          3'd1:    b = lo(ax);
          3'd2:    b = hi(ax);
          3'd3:    b = lo(ay);
          3'd4:    b = hi(ay);
          3'd5:    b = lo(az);
          3'd6:    b = hi(az);
`ifdef UART_FRAME_CHECKSUM_EN
          3'd7:    b = lo(ax) + hi(ax) + lo(ay) + hi(ay) + lo(az) + hi(az);
`endif
          default: b = 8'h00;
        endcase
      end
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  // Grant decode: a queued command always beats a pending stream frame.
  always_comb begin
    grant_cmd    = (state == StIdle) && cmd_pend;
    grant_stream = (state == StIdle) && !cmd_pend && stream_pend;
    grant_byte   = grant_cmd ? cmd_byte : CMD_A;
    tick         = stream_on && (stream_cnt == DIV_LAST);
    last_idx     = (cur_cmd == CMD_A) ? FRAME_LAST : 3'd0;
    idx_next     = idx + 3'd1;
  end

  // Command slot, streaming enable, stream timer and coalescing pending flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_pend    <= 1'b0;
      cmd_byte    <= 8'h00;
      cmd_drop    <= 1'b0;
      stream_on   <= 1'b0;
      stream_pend <= 1'b0;
      stream_cnt  <= 32'd0;
    end else begin
      cmd_drop <= 1'b0;
      if (grant_cmd)    cmd_pend    <= 1'b0;
      if (grant_stream) stream_pend <= 1'b0;
      if (stream_on) begin
        if (tick) begin
          stream_cnt  <= 32'd0;
          stream_pend <= 1'b1;
        end else begin
          stream_cnt <= stream_cnt + 32'd1;
        end
      end else begin
        stream_cnt <= 32'd0;
      end
      if (rx_valid) begin
        if (rx_data == CMD_S) begin
          stream_on <= 1'b1;
        end else if (rx_data == CMD_SS) begin
          // Stop also drops any tick that has not been granted yet.
          stream_on   <= 1'b0;
          stream_pend <= 1'b0;
          stream_cnt  <= 32'd0;
        end else if (!cmd_pend || grant_cmd) begin
          cmd_pend <= 1'b1;
          cmd_byte <= rx_data;
        end else begin
          cmd_drop <= 1'b1;
        end
      end
    end
  end

  // Transaction FSM with registered tx_start/tx_data/frame_active.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= StIdle;
      tx_start     <= 1'b0;
      tx_data      <= 8'h00;
      frame_active <= 1'b0;
      cur_cmd      <= 8'h00;
      idx          <= 3'd0;
      snap_x       <= 13'd0;
      snap_y       <= 13'd0;
      snap_z       <= 13'd0;
    end else begin
      case (state)
        StIdle: begin
          if (grant_cmd || grant_stream) begin
            snap_x       <= x_axis;
            snap_y       <= y_axis;
            snap_z       <= z_axis;
            cur_cmd      <= grant_byte;
            idx          <= 3'd0;
            frame_active <= 1'b1;
            // Snapshot lands this edge, so the first byte comes from the live inputs.
            tx_data      <= pick(grant_byte, 3'd0, x_axis, y_axis, z_axis);
            tx_start     <= !tx_busy;
            state        <= StSend;
          end
        end
        StSend: begin
          if (tx_start) begin
            tx_start <= 1'b0;
            state    <= StAck;
          end else begin
            tx_start <= !tx_busy;
          end
        end
        StAck: begin
          state <= StDone;
        end
        StDone: begin
          if (!tx_busy) begin
            if (idx != last_idx) begin
              idx      <= idx_next;
              tx_data  <= pick(cur_cmd, idx_next, snap_x, snap_y, snap_z);
              tx_start <= 1'b1;
              state    <= StSend;
            end else begin
              frame_active <= 1'b0;
              state        <= StIdle;
            end
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched: a stub transmitter, a scoreboard queue of
// expected bytes, and directed scenarios for commands, frames, streaming and reset.
module tb_uart_tx_sched;

`ifdef UART_FRAME_CHECKSUM_EN
  localparam int FLEN = 8;
`else
  localparam int FLEN = 7;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic [12:0] x_axis = 13'h0123;
  logic [12:0] y_axis = 13'h1FFF;
  logic [12:0] z_axis = 13'h0F00;
  logic        tx_busy;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        frame_active;
  logic        stream_on;
  logic        cmd_drop;

  logic        hold_busy = 1'b0;
  int          busy_len = 10;
  logic [7:0]  stub_cnt;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          n_starts = 0;
  int          starts[$];
  logic [7:0]  exp_q[$];
  logic [7:0]  held = 8'h00;
  logic        busy_q = 1'b0;
  logic        prev_start = 1'b0;

  uart_tx_sched #(.STREAM_DIV(16), .HDR(8'hA5)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
    .x_axis(x_axis), .y_axis(y_axis), .z_axis(z_axis), .tx_busy(tx_busy),
    .tx_start(tx_start), .tx_data(tx_data), .frame_active(frame_active),
    .stream_on(stream_on), .cmd_drop(cmd_drop)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Stub transmitter: busy rises the cycle after tx_start and lasts busy_len cycles.
  always @(posedge clk) begin
    if (rst) stub_cnt <= 8'd0;
    else if (tx_start) stub_cnt <= busy_len[7:0];
    else if (stub_cnt != 8'd0) stub_cnt <= stub_cnt - 8'd1;
  end
  assign tx_busy = (stub_cnt != 8'd0) || hold_busy;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard monitor: pops an expected byte for every tx_start.
  always @(negedge clk) begin
    if (rst) begin
      prev_start = 1'b0;
    end else begin
      if (tx_start) begin
        check("start_consecutive", {31'd0, prev_start}, 32'd0);
        n_starts++;
        starts.push_back(cyc);
        check("byte_expected", {31'd0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0) check("tx_byte", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
        held = tx_data;
      end
      if (busy_q && stub_cnt == 8'd0) check("data_hold", {24'd0, tx_data}, {24'd0, held});
      prev_start = tx_start;
    end
    busy_q = (stub_cnt != 8'd0);
  end

  function automatic logic [7:0] lo8(input logic [12:0] a);
    return a[7:0];
  endfunction

  function automatic logic [7:0] hi8(input logic [12:0] a);
    return {{3{a[12]}}, a[12:8]};
  endfunction

  task automatic push_frame(input logic [12:0] ax, input logic [12:0] ay, input logic [12:0] az);
    logic [7:0] b[6];
    logic [7:0] sum;
    b[0] = lo8(ax); b[1] = hi8(ax); b[2] = lo8(ay);
    b[3] = hi8(ay); b[4] = lo8(az); b[5] = hi8(az);
    exp_q.push_back(8'hA5);
    sum = 8'h00;
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(b[i]);
      sum = sum + b[i];
    end
    if (FLEN == 8) exp_q.push_back(sum);
  endtask

  task automatic send_byte(input logic [7:0] b, output int t0, output logic drop);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    t0       = cyc;
    @(negedge clk);
    rx_valid = 1'b0;
    drop     = cmd_drop;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(exp_q.size() == 0 && !frame_active && stub_cnt == 8'd0) && n < 3000);
    check(tag, exp_q.size(), 32'd0);
  endtask

  task automatic wait_starts(input int target, input string tag);
    int n;
    n = 0;
    while (n_starts < target && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check(tag, {31'd0, n_starts >= target}, 32'd1);
  endtask

  initial begin
    logic [7:0] sc_cmd[7];
    logic [7:0] sc_exp[7];
    logic [7:0] fr_exp[8];
    int t0, t1, base, sbase, n;
    logic drop;

    sc_cmd = '{8'h78, 8'h58, 8'h59, 8'h41, 8'h79, 8'h7A, 8'h5A};
    sc_exp = '{8'h23, 8'h01, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'h0F};
    fr_exp = '{8'hA5, 8'h23, 8'h01, 8'hFF, 8'hFF, 8'h00, 8'h0F, 8'h31};

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_tx_start", {31'd0, tx_start}, 32'd0);
    check("rst_tx_data", {24'd0, tx_data}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_frame_active", {31'd0, frame_active}, 32'd0);
    check("rst_stream_on", {31'd0, stream_on}, 32'd0);
    check("rst_cmd_drop", {31'd0, cmd_drop}, 32'd0);

    // Single-byte commands and 2-cycle latency
    for (int i = 0; i < 7; i++) begin
      exp_q.push_back(sc_exp[i]);
      send_byte(sc_cmd[i], t0, drop);
      n = 0;
      while (!tx_start && n < 20) begin
        @(negedge clk);
        n++;
      end
      check("single_latency", cyc - t0, 32'd2);
      wait_idle("single_idle");
    end

    // Full frame with axis inputs changed after the header goes out
    for (int i = 0; i < FLEN; i++) exp_q.push_back(fr_exp[i]);
    base = n_starts;
    send_byte(8'h61, t0, drop);
    wait_starts(base + 1, "frame_first");
    x_axis = 13'($urandom); y_axis = 13'($urandom); z_axis = 13'($urandom);
    wait_idle("frame_idle");
    check("frame_count", n_starts - base, FLEN);
    x_axis = 13'h0123; y_axis = 13'h1FFF; z_axis = 13'h0F00;

    // Slot overflow during a frame
    push_frame(x_axis, y_axis, z_axis);
    exp_q.push_back(8'h23);
    send_byte(8'h61, t0, drop);
    repeat (3) @(negedge clk);
    send_byte(8'h78, t0, drop);
    check("ovf_x_nodrop", {31'd0, drop}, 32'd0);
    send_byte(8'h79, t0, drop);
    check("ovf_y_drop", {31'd0, drop}, 32'd1);
    wait_idle("ovf_idle");

    // Handshake: busy held high before SEND
    hold_busy = 1'b1;
    base = n_starts;
    exp_q.push_back(8'h01);
    send_byte(8'h58, t0, drop);
    repeat (10) @(negedge clk);
    check("hs_withheld", n_starts - base, 32'd0);
    check("hs_data", {24'd0, tx_data}, 32'h01);
    check("hs_active", {31'd0, frame_active}, 32'd1);
    hold_busy = 1'b0;
    t0 = cyc;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tx_start && n < 20);
    check("hs_release_latency", cyc - t0, 32'd1);
    wait_idle("hs_idle");

    // Priority: a queued command beats a pending stream tick
    hold_busy = 1'b1;
    base = n_starts;
    exp_q.push_back(8'h23);
    exp_q.push_back(8'hFF);
    push_frame(x_axis, y_axis, z_axis);
    send_byte(8'h78, t0, drop);
    send_byte(8'h73, t0, drop);
    repeat (20) @(negedge clk);
    send_byte(8'h79, t0, drop);
    check("prio_y_nodrop", {31'd0, drop}, 32'd0);
    hold_busy = 1'b0;
    wait_starts(base + 3, "prio_hdr");
    send_byte(8'h53, t0, drop);
    wait_idle("prio_idle");
    repeat (100) @(negedge clk);
    check("prio_count", n_starts - base, 2 + FLEN);
    check("prio_stream_off", {31'd0, stream_on}, 32'd0);

    // Streaming with a 40-cycle transmitter: frames back to back, ticks coalesce
    busy_len = 40;
    x_axis = 13'h1ABC; y_axis = 13'h0055; z_axis = 13'h1000;
    push_frame(x_axis, y_axis, z_axis);
    push_frame(x_axis, y_axis, z_axis);
    base  = n_starts;
    sbase = starts.size();
    send_byte(8'h73, t0, drop);
    check("stream_on_set", {31'd0, stream_on}, 32'd1);
    wait_starts(base + FLEN + 1, "stream_second");
    send_byte(8'h53, t1, drop);
    wait_idle("stream_idle");
    repeat (60) @(negedge clk);
    check("stream_count", n_starts - base, 2 * FLEN);
    if (starts.size() >= sbase + 2 * FLEN) begin
      check("stream_first_latency", starts[sbase] - t0, 32'd18);
      for (int i = 1; i < 2 * FLEN; i++)
        check("stream_gap", starts[sbase+i] - starts[sbase+i-1], (i % FLEN == 0) ? 43 : 42);
    end

    // Reset mid-frame during byte 3
    busy_len = 10;
    x_axis = 13'h0123; y_axis = 13'h1FFF; z_axis = 13'h0F00;
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h23);
    exp_q.push_back(8'h01);
    send_byte(8'h61, t0, drop);
    send_byte(8'h73, t0, drop);
    n = 0;
    t1 = 0;
    while (t1 < 3 && n < 500) begin
      @(negedge clk);
      n++;
      if (tx_start) t1++;
    end
    check("mid_byte3_seen", t1, 32'd3);
    rst = 1'b1;
    #1;
    check("mid_rst_tx_start", {31'd0, tx_start}, 32'd0);
    check("mid_rst_stream_on", {31'd0, stream_on}, 32'd0);
    check("mid_rst_frame_active", {31'd0, frame_active}, 32'd0);
    check("mid_rst_tx_data", {24'd0, tx_data}, 32'd0);
    repeat (2) @(negedge clk);
    exp_q.delete();
    rst = 1'b0;
    base = n_starts;
    exp_q.push_back(8'h23);
    send_byte(8'h78, t0, drop);
    wait_idle("post_rst_idle");
    repeat (60) @(negedge clk);
    check("post_rst_count", n_starts - base, 32'd1);
    check("post_rst_stream_off", {31'd0, stream_on}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
